// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the pipeline hazard/stall controller.
//   state_t   : sequencing FSM states (RUN, LDSTALL, REDIR_PEND)
//   REG_ZERO  : architectural zero register; never a real producer
//   NOP_*     : encoding of the bubble loaded into flushed pipeline registers
//   STALL_CNT_W : width of the load-use stall down-counter
// -----------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LDSTALL    = 2'd1,
    REDIR_PEND = 2'd2
  } state_t;

  localparam logic [4:0]  REG_ZERO    = 5'b0;
  localparam int unsigned STALL_CNT_W = 3;

  // A bubble is an all-zero instruction word writing the zero register.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [4:0]  NOP_RD    = REG_ZERO;

endpackage

// File: rtl/load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
// Combinational load-use hazard detection between the load in EXE and the
// consumer in the REG stage. A load into r0 never creates a dependency.
// Ports:
//   Rs_id_reg, Rt_id_reg  in  REG-stage source registers
//   Uses_rt_id_reg        in  REG-stage instruction actually reads Rt
//   Rd_reg_exe            in  destination of the instruction in EXE
//   Memread_reg_exe       in  instruction in EXE is a load
//   hz                    out load-use hazard present this cycle
// -----------------------------------------------------------------------------
module load_use_detect
  import hazard_pkg::*;
(
  input  logic [4:0] Rs_id_reg,
  input  logic [4:0] Rt_id_reg,
  input  logic       Uses_rt_id_reg,
  input  logic [4:0] Rd_reg_exe,
  input  logic       Memread_reg_exe,
  output logic       hz
);

  assign hz = Memread_reg_exe
            & (Rd_reg_exe != REG_ZERO)
            & ((Rd_reg_exe == Rs_id_reg)
               | (Uses_rt_id_reg & (Rd_reg_exe == Rt_id_reg)));

endmodule

// File: rtl/hazard_stall_controller.sv
// -----------------------------------------------------------------------------
// hazard_stall_controller
// Sequencing controller for the 6-stage pipe (IF, ID, REG, EXE, MEM, WB).
// Handles the hazards operand forwarding cannot: load-use stalls of
// LOAD_USE_STALL cycles, taken-branch flushes and a whole-pipe freeze while
// data memory is not ready. Priority: Ext_stall > Branch_taken_exe > hz.
// A branch arriving during a freeze is parked in REDIR_PEND and applied in the
// first unfrozen cycle.
// Outputs are combinational from state and inputs.
// Optional build macro: HAZARD_PERF_CNT_EN enables saturating performance
// counters; otherwise Perf_* are tied to zero.
// Ports:
//   clk, reset (sync, active-high)
//   Rs_id_reg, Rt_id_reg, Uses_rt_id_reg, Rd_reg_exe, Memread_reg_exe
//   Branch_taken_exe, Ext_stall
//   Pc_write, Pc_redirect, If_id_write, Id_reg_write
//   Flush_if_id, Flush_id_reg, Bubble_reg_exe, Mem_freeze
//   Perf_stall_cnt, Perf_flush_cnt (CNT_W bits)
// -----------------------------------------------------------------------------
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int unsigned LOAD_USE_STALL = 1,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs_id_reg,
  input  logic [4:0]       Rt_id_reg,
  input  logic             Uses_rt_id_reg,
  input  logic [4:0]       Rd_reg_exe,
  input  logic             Memread_reg_exe,
  input  logic             Branch_taken_exe,
  input  logic             Ext_stall,
  output logic             Pc_write,
  output logic             Pc_redirect,
  output logic             If_id_write,
  output logic             Id_reg_write,
  output logic             Flush_if_id,
  output logic             Flush_id_reg,
  output logic             Bubble_reg_exe,
  output logic             Mem_freeze,
  output logic [CNT_W-1:0] Perf_stall_cnt,
  output logic [CNT_W-1:0] Perf_flush_cnt
);

  // The hz cycle itself is the first stall cycle, so the counter holds the rest.
  localparam logic [STALL_CNT_W-1:0] STALL_RELOAD = STALL_CNT_W'(LOAD_USE_STALL - 32'd1);

  state_t                 state_r, state_nxt_s;
  logic [STALL_CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic                   hz_s;

  load_use_detect u_load_use_detect (
    .Rs_id_reg       (Rs_id_reg),
    .Rt_id_reg       (Rt_id_reg),
    .Uses_rt_id_reg  (Uses_rt_id_reg),
    .Rd_reg_exe      (Rd_reg_exe),
    .Memread_reg_exe (Memread_reg_exe),
    .hz              (hz_s)
  );

  // State and stall counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= RUN;
      cnt_r   <= {STALL_CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state and pipeline control outputs.
  always_comb begin
    Pc_write       = 1'b1;
    Pc_redirect    = 1'b0;
    If_id_write    = 1'b1;
    Id_reg_write   = 1'b1;
    Flush_if_id    = 1'b0;
    Flush_id_reg   = 1'b0;
    Bubble_reg_exe = 1'b0;
    Mem_freeze     = 1'b0;
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;

    if (reset) begin
      Pc_write       = 1'b0;
      If_id_write    = 1'b0;
      Id_reg_write   = 1'b0;
      Flush_if_id    = 1'b1;
      Flush_id_reg   = 1'b1;
      Bubble_reg_exe = 1'b1;
    end else if (Ext_stall) begin
      Mem_freeze   = 1'b1;
      Pc_write     = 1'b0;
      If_id_write  = 1'b0;
      Id_reg_write = 1'b0;
      // Park a branch that resolves during the freeze so it is not lost.
      if (Branch_taken_exe) begin
        state_nxt_s = REDIR_PEND;
      end else begin
        state_nxt_s = state_r;
      end
    end else begin
      case (state_r)
        RUN: begin
          if (Branch_taken_exe) begin
            // The hz consumer is flushed, so the hazard is moot.
            Pc_redirect    = 1'b1;
            Pc_write       = 1'b1;
            Flush_if_id    = 1'b1;
            Flush_id_reg   = 1'b1;
            Bubble_reg_exe = 1'b1;
            state_nxt_s    = RUN;
          end else if (hz_s) begin
            Pc_write       = 1'b0;
            If_id_write    = 1'b0;
            Id_reg_write   = 1'b0;
            Bubble_reg_exe = 1'b1;
            if (LOAD_USE_STALL > 32'd1) begin
              state_nxt_s = LDSTALL;
              cnt_nxt_s   = STALL_RELOAD;
            end else begin
              state_nxt_s = RUN;
            end
          end else begin
            state_nxt_s = RUN;
          end
        end
        LDSTALL: begin
          Pc_write       = 1'b0;
          If_id_write    = 1'b0;
          Id_reg_write   = 1'b0;
          Bubble_reg_exe = 1'b1;
          if (cnt_r <= 3'd1) begin
            state_nxt_s = RUN;
            cnt_nxt_s   = 3'd0;
          end else begin
            cnt_nxt_s   = cnt_r - 3'd1;
          end
        end
        REDIR_PEND: begin
          Pc_redirect    = 1'b1;
          Pc_write       = 1'b1;
          Flush_if_id    = 1'b1;
          Flush_id_reg   = 1'b1;
          Bubble_reg_exe = 1'b1;
          state_nxt_s    = RUN;
        end
        default: begin
          state_nxt_s = RUN;
          cnt_nxt_s   = 3'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;
  logic             stall_evt_s, flush_evt_s;

  // A bubble without an IF_ID flush only comes from a load-use stall.
  assign stall_evt_s = Bubble_reg_exe & ~Flush_if_id;
  assign flush_evt_s = Pc_redirect;

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stall_evt_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_evt_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign Perf_stall_cnt = stall_cnt_r;
  assign Perf_flush_cnt = flush_cnt_r;
`else
  assign Perf_stall_cnt = {CNT_W{1'b0}};
  assign Perf_flush_cnt = {CNT_W{1'b0}};
`endif

endmodule
